evm_ballot_timer: RTL and testbench
===================================

Name: evm_ballot_timer

Overview:
- Downstream consumer of the EVM slow-clock divider output (the ~3.7 Hz square wave toggled from clk_50m).
- Converts that level into a one-cycle tick in the clk_50m domain.
- Runs the per-voter ballot session: officer arms, voter gets a timed window to press exactly one candidate button, one vote is emitted, then a lockout runs.
- Output feeds the vote tally counters.

Parameters:
- NUM_CAND, 4, number of candidate buttons; must be ≤ 2^ID_W.
- ID_W, 2, width of vote_id.
- VOTE_TIMEOUT, 30, ticks allowed in ARMED before the session is abandoned; must be ≥ 1.
- LOCK_TICKS, 3, minimum ticks spent in LOCKOUT after a vote; 0 is legal.
- CNT_W, 8, width of the tick countdown; must hold max(VOTE_TIMEOUT, LOCK_TICKS).

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- tick_in  in  1  slow divided clock level, treated as asynchronous
- arm  in  1  single-cycle officer arm pulse, synchronous, debounced upstream
- vote_btn  in  NUM_CAND  candidate buttons, level, synchronous, debounced upstream
- ballot_ready  out  1  high while ARMED (voter lamp)
- vote_valid  out  1  one-cycle pulse, one accepted vote
- vote_id  out  ID_W  index of the last accepted candidate
- time_left  out  CNT_W  remaining ARMED ticks; 0 outside ARMED
- timeout  out  1  one-cycle pulse, session expired without a vote
- multi_press  out  1  one-cycle pulse, more than one button seen while ARMED

Behaviour:
- Clock and reset: one clock, clk_50m. Reset rst_n is asynchronous, active-low.
- All flops reset to 0: sync stages, edge-detect flop, state = IDLE, counters, and all outputs.
- Reset asserted mid-session aborts it. No vote_valid or timeout pulse is produced.

Tick generation:
- tick_in passes through a 2-FF synchronizer, then rising-edge detect.
- tick_pulse is high for exactly one clk_50m cycle per tick_in rising edge.
- Latency from tick_in rising to tick_pulse is 2–3 cycles.
- Falling edges are ignored.

State machine (IDLE, ARMED, LOCKOUT); all outputs are registered.

IDLE:
- ballot_ready = 0, time_left = 0.
- arm = 1: go to ARMED and load time_left = VOTE_TIMEOUT.
- Buttons and ticks are ignored.

ARMED:
- ballot_ready = 1. arm is ignored, so time_left is not reloaded.
- Exactly one vote_btn bit high at a clock edge:
  - vote_id <= index of that bit.
  - vote_valid high for the following cycle only.
  - time_left <= 0, load lock counter = LOCK_TICKS, go to LOCKOUT.
- Two or more bits high:
  - multi_press pulses for one cycle.
  - Stay in ARMED and accept no vote.
  - multi_press re-pulses every cycle the condition persists.
- tick_pulse with no valid press: time_left decrements.
- tick_pulse while time_left == 1 and no valid press:
  - timeout pulses for one cycle, time_left <= 0, go to IDLE.
- Valid press in the same cycle as the final tick: the vote wins. No timeout pulse, time_left is not decremented.
- multi_press in the same cycle as the final tick: timeout is taken and multi_press also pulses.

LOCKOUT:
- ballot_ready = 0. Buttons are never accepted and arm is ignored.
- tick_pulse with lock counter > 0: decrement.
- Exit to IDLE when lock counter == 0 and vote_btn == 0 in the same cycle.
- A held button keeps the block in LOCKOUT indefinitely.
- LOCK_TICKS = 0: exit on the first cycle with all buttons released.

Output holding:
- vote_id holds its value until the next accepted vote.
- vote_valid, timeout and multi_press are never high for two consecutive cycles from a single event, except multi_press while the multi-press condition persists.
- Counter arithmetic is unsigned. The counter never decrements below 0 (saturates).

Test Plan:
- Reset, then arm pulse → ballot_ready = 1, time_left = 30. Hold vote_btn = 4'b0100 → vote_valid one cycle, vote_id = 2, ballot_ready = 0. Release, then 3 tick_in rising edges → IDLE.
- Arm, apply 30 tick_in rising edges with no press → time_left steps 30..1, then timeout one cycle, IDLE, time_left = 0, no vote_valid.
- Arm, vote_btn = 4'b0011 for 5 cycles → multi_press high 5 cycles, no vote_valid. Then 4'b1000 → vote_valid, vote_id = 3.
- Arm, let time_left reach 1, press 4'b0001 in the exact cycle tick_pulse fires → vote_valid, vote_id = 0, no timeout.
- After a vote keep the button held past 10 ticks → stays in LOCKOUT, ballot_ready = 0. A second arm pulse is ignored. Release → IDLE next cycle.
- Assert rst_n = 0 while ARMED with time_left = 12 → all outputs 0 immediately, state IDLE. Button presses after release are ignored until arm.

Source files
------------

// File: rtl/evm_ballot_timer.sv
// evm_ballot_timer
// Turns the slow divider level into a single clk_50m tick and runs one voter's
// ballot session: arm, timed voting window, single vote out, then lockout.
`timescale 1ns/1ps

module evm_ballot_timer #(
    parameter int NUM_CAND     = 4,
    parameter int ID_W         = 2,
    parameter int VOTE_TIMEOUT = 30,
    parameter int LOCK_TICKS   = 3,
    parameter int CNT_W        = 8
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic                tick_in,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] vote_btn,
    output logic                ballot_ready,
    output logic                vote_valid,
    output logic [ID_W-1:0]     vote_id,
    output logic [CNT_W-1:0]    time_left,
    output logic                timeout,
    output logic                multi_press
);

    localparam int BC_W = $clog2(NUM_CAND + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKOUT
    } state_t;

    state_t           state;
    logic             tick_meta;
    logic             tick_sync;
    logic             tick_prev;
    logic             tick_pulse;
    logic [CNT_W-1:0] lock_cnt;
    logic [BC_W-1:0]  btn_count;
    logic [ID_W-1:0]  btn_idx;
    logic             single_press;
    logic             many_press;

    // Two-stage synchronizer on the slow level plus a delayed copy for edge detect
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tick_meta <= 1'b0;
            tick_sync <= 1'b0;
            tick_prev <= 1'b0;
        end else begin
            tick_meta <= tick_in;
            tick_sync <= tick_meta;
            tick_prev <= tick_sync;
        end
    end

    assign tick_pulse = tick_sync & ~tick_prev;

    // Count pressed buttons and remember the index of the (last) pressed one
    always_comb begin
        btn_count = '0;
        btn_idx   = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_btn[i]) begin
                btn_count = btn_count + BC_W'(1);
                btn_idx   = ID_W'(i);
            end
        end
    end

    assign single_press = (btn_count == BC_W'(1));
    assign many_press   = (btn_count >  BC_W'(1));

    // Session state machine; every output is a registered copy of its decision
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lock_cnt     <= '0;
            ballot_ready <= 1'b0;
            vote_valid   <= 1'b0;
            vote_id      <= '0;
            time_left    <= '0;
            timeout      <= 1'b0;
            multi_press  <= 1'b0;
        end else begin
            vote_valid  <= 1'b0;
            timeout     <= 1'b0;
            multi_press <= 1'b0;

            case (state)
                IDLE: begin
                    ballot_ready <= 1'b0;
                    time_left    <= '0;
                    if (arm) begin
                        state        <= ARMED;
                        ballot_ready <= 1'b1;
                        time_left    <= CNT_W'(VOTE_TIMEOUT);
                    end
                end

                ARMED: begin
                    if (single_press) begin
                        vote_id      <= btn_idx;
                        vote_valid   <= 1'b1;
                        time_left    <= '0;
                        lock_cnt     <= CNT_W'(LOCK_TICKS);
                        ballot_ready <= 1'b0;
                        state        <= LOCKOUT;
                    end else begin
                        if (many_press) begin
                            multi_press <= 1'b1;
                        end
                        if (tick_pulse) begin
                            if (time_left <= CNT_W'(1)) begin
                                timeout      <= 1'b1;
                                time_left    <= '0;
                                ballot_ready <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                time_left <= time_left - CNT_W'(1);
                            end
                        end
                    end
                end

                LOCKOUT: begin
                    ballot_ready <= 1'b0;
                    time_left    <= '0;
                    if (tick_pulse && (lock_cnt != '0)) begin
                        lock_cnt <= lock_cnt - CNT_W'(1);
                    end
                    if ((lock_cnt == '0) && (vote_btn == '0)) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    ballot_ready <= 1'b0;
                    time_left    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evm_ballot_timer.sv
// tb_evm_ballot_timer
// Directed bench for the ballot session timer with hand-computed expectations.
`timescale 1ns/1ps

module tb_evm_ballot_timer;

    logic       clk_50m;
    logic       rst_n;
    logic       tick_in;
    logic       arm;
    logic [3:0] vote_btn;
    logic       ballot_ready;
    logic       vote_valid;
    logic [1:0] vote_id;
    logic [7:0] time_left;
    logic       timeout;
    logic       multi_press;

    int n_checks;
    int n_fail;

    evm_ballot_timer dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .tick_in      (tick_in),
        .arm          (arm),
        .vote_btn     (vote_btn),
        .ballot_ready (ballot_ready),
        .vote_valid   (vote_valid),
        .vote_id      (vote_id),
        .time_left    (time_left),
        .timeout      (timeout),
        .multi_press  (multi_press)
    );

    // 50 MHz system clock
    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    // Hard stop in case the sequence below ever stalls
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_50m);
    endtask

    // Rising edge of the slow level; returns in the cycle right after the FSM saw the tick
    task automatic tick_rise();
        tick_in = 1'b1;
        wait_neg(3);
    endtask

    task automatic tick_fall();
        tick_in = 1'b0;
        wait_neg(3);
    endtask

    task automatic send_tick();
        tick_rise();
        tick_fall();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        wait_neg(1);
        arm = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tick_in  = 1'b0;
        arm      = 1'b0;
        vote_btn = 4'b0000;
        wait_neg(3);

        // Reset state
        check_output("rst_ready",   ballot_ready, 0);
        check_output("rst_valid",   vote_valid,   0);
        check_output("rst_id",      vote_id,      0);
        check_output("rst_left",    time_left,    0);
        check_output("rst_timeout", timeout,      0);
        check_output("rst_multi",   multi_press,  0);
        rst_n = 1'b1;
        wait_neg(2);

        // Basic vote for candidate 2
        arm_pulse();
        check_output("t1_ready", ballot_ready, 1);
        check_output("t1_left",  time_left,    30);
        vote_btn = 4'b0100;
        wait_neg(1);
        check_output("t1_valid",       vote_valid,   1);
        check_output("t1_id",          vote_id,      2);
        check_output("t1_ready_after", ballot_ready, 0);
        check_output("t1_left_after",  time_left,    0);
        vote_btn = 4'b0000;
        wait_neg(1);
        check_output("t1_valid_one", vote_valid, 0);
        send_tick();
        send_tick();
        arm_pulse();
        wait_neg(1);
        check_output("t1_lock_arm_ignored", ballot_ready, 0);
        send_tick();
        wait_neg(1);
        arm_pulse();
        check_output("t1_idle_rearm", ballot_ready, 1);
        check_output("t1_rearm_left", time_left,    30);

        // Full timeout with no press
        for (int k = 0; k < 29; k++) begin
            send_tick();
            check_output("t2_left", time_left, 29 - k);
        end
        tick_rise();
        check_output("t2_timeout",     timeout,      1);
        check_output("t2_left_zero",   time_left,    0);
        check_output("t2_ready_drop",  ballot_ready, 0);
        check_output("t2_no_valid",    vote_valid,   0);
        tick_fall();
        check_output("t2_timeout_one", timeout, 0);
        arm_pulse();
        wait_neg(1);
        check_output("t2_idle_rearm", ballot_ready, 1);

        // Multi-press held five cycles, then a single press wins
        vote_btn = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            wait_neg(1);
            check_output("t3_multi",    multi_press, 1);
            check_output("t3_no_valid", vote_valid,  0);
        end
        vote_btn = 4'b1000;
        wait_neg(1);
        check_output("t3_valid",    vote_valid,  1);
        check_output("t3_id",       vote_id,     3);
        check_output("t3_multi_end", multi_press, 0);
        vote_btn = 4'b0000;
        send_tick();
        send_tick();
        send_tick();
        wait_neg(1);

        // Press lands on the same cycle as the final tick
        arm_pulse();
        check_output("t4_left_start", time_left, 30);
        for (int k = 0; k < 29; k++) send_tick();
        check_output("t4_left_one", time_left, 1);
        tick_in = 1'b1;
        wait_neg(2);
        vote_btn = 4'b0001;
        wait_neg(1);
        check_output("t4_valid",      vote_valid, 1);
        check_output("t4_id",         vote_id,    0);
        check_output("t4_no_timeout", timeout,    0);
        check_output("t4_left",       time_left,  0);
        tick_fall();

        // Held button keeps lockout alive; arm ignored; release frees it
        for (int k = 0; k < 11; k++) send_tick();
        check_output("t5_ready_locked", ballot_ready, 0);
        arm_pulse();
        wait_neg(1);
        check_output("t5_arm_ignored", ballot_ready, 0);
        check_output("t5_id_hold",     vote_id,      0);
        check_output("t5_no_revote",   vote_valid,   0);
        vote_btn = 4'b0000;
        wait_neg(1);
        arm_pulse();
        check_output("t5_idle_next", ballot_ready, 1);

        // Asynchronous reset in the middle of a session
        for (int k = 0; k < 18; k++) send_tick();
        check_output("t6_left_12", time_left, 12);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_ready", ballot_ready, 0);
        check_output("t6_rst_left",  time_left,    0);
        check_output("t6_rst_valid", vote_valid,   0);
        check_output("t6_rst_tout",  timeout,      0);
        wait_neg(2);
        rst_n = 1'b1;
        vote_btn = 4'b0010;
        wait_neg(3);
        check_output("t6_btn_ignored", vote_valid,   0);
        check_output("t6_still_idle",  ballot_ready, 0);
        check_output("t6_id_cleared",  vote_id,      0);
        vote_btn = 4'b0000;
        wait_neg(1);
        arm_pulse();
        check_output("t6_rearm", ballot_ready, 1);
        check_output("t6_rearm_left", time_left, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
